// File: rtl/mf_pkg.sv
// mf_pkg: state encoding, window geometry and offset helpers shared by the median filter engine.
package mf_pkg;
    localparam int BYTES_PER_PIXEL = 3;
    localparam int CHANNEL_WIDTH = 8;
    localparam int WINDOW_SIZE = 9;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, COMPUTE, WRITE, DONE} mf_state_t;

    function automatic logic [1:0] win_row(input logic [3:0] k);
        return (k >= 4'd6) ? 2'd2 : (k >= 4'd3) ? 2'd1 : 2'd0;
    endfunction

    function automatic logic [1:0] win_col(input logic [3:0] k);
        return 2'(k - 4'd3 * 4'(win_row(k)));
    endfunction
endpackage

// File: rtl/median9.sv
// median9: combinational 9-input median of 8-bit values using the 19-exchange pruned sorting network.
module median9
    import mf_pkg::*;
(
    input  logic [WINDOW_SIZE-1:0][CHANNEL_WIDTH-1:0] i_pix,
    output logic [CHANNEL_WIDTH-1:0]                  o_med
);
    // Each pair leaves the smaller value in LO; only the exchanges that affect slot 4 are kept.
    localparam logic [3:0] LO [19] = '{4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
                                       4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4};
    localparam logic [3:0] HI [19] = '{4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
                                       4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2};

    logic [WINDOW_SIZE-1:0][CHANNEL_WIDTH-1:0] w_p;

    always_comb begin
        w_p = i_pix;
        for (int i = 0; i < 19; i++)
            if (w_p[LO[i]] > w_p[HI[i]]) {w_p[LO[i]], w_p[HI[i]]} = {w_p[HI[i]], w_p[LO[i]]};
    end

    assign o_med = w_p[4];
endmodule

// File: rtl/median_filter_engine.sv
// median_filter_engine: 3x3 per-channel median filter over a memory-resident RGB image;
// border pixels (and every pixel of images narrower or shorter than 3) are copied unchanged.
module median_filter_engine
    import mf_pkg::*;
#(
    parameter int              IMG_WIDTH  = 640,
    parameter int              IMG_HEIGHT = 480,
    parameter longint unsigned SRC_BASE   = 0,
    parameter longint unsigned DST_BASE   = 2097152,
    parameter int              BUS_WIDTH  = 32,
    parameter int              DATA_WIDTH = 24
) (
    input  logic                  Mf_Clk,
    input  logic                  Mf_Reset_n,
    input  logic                  Mf_Start,
    output logic                  Mf_Busy,
    output logic                  Mf_Done,
    output logic                  Mf_Mem_Read_Enable,
    output logic [BUS_WIDTH-1:0]  Mf_Mem_Read_Address,
    input  logic [DATA_WIDTH-1:0] Mf_Mem_Read_Data,
    output logic                  Mf_Mem_Write_Enable,
    output logic [BUS_WIDTH-1:0]  Mf_Mem_Write_Address,
    output logic [DATA_WIDTH-1:0] Mf_Mem_Write_Data
);
    localparam int RW = $clog2(IMG_HEIGHT) + 1;
    localparam int CW = $clog2(IMG_WIDTH) + 1;
    localparam bit SMALL = (IMG_WIDTH < 3) || (IMG_HEIGHT < 3);

    mf_state_t             r_state, w_next;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;
    logic [3:0]            r_k, r_cap_k;
    logic                  r_cap_v;
    logic [DATA_WIDTH-1:0] r_win [WINDOW_SIZE];
    logic [DATA_WIDTH-1:0] r_med, w_med;
    logic                  w_interior, w_last_k, w_last_col, w_last_pix;
    logic [63:0]           w_rd_row, w_rd_col;
    logic [2:0][WINDOW_SIZE-1:0][CHANNEL_WIDTH-1:0] w_chan;

    function automatic logic [BUS_WIDTH-1:0] pix_addr(input logic [63:0] base, input logic [63:0] row,
                                                      input logic [63:0] col);
        return BUS_WIDTH'(base + (row * 64'(IMG_WIDTH) + col) * 64'(BYTES_PER_PIXEL));
    endfunction

    assign w_interior = !SMALL && r_row != '0 && r_col != '0 &&
                        int'(r_row) < IMG_HEIGHT - 1 && int'(r_col) < IMG_WIDTH - 1;
    assign w_last_k   = w_interior ? (r_k == 4'd8) : 1'b1;
    assign w_last_col = int'(r_col) == IMG_WIDTH - 1;
    assign w_last_pix = w_last_col && int'(r_row) == IMG_HEIGHT - 1;
    // Border pixels fetch only their centre, i.e. window offset (1,1).
    assign w_rd_row   = 64'(r_row) + 64'(w_interior ? win_row(r_k) : 2'd1) - 64'd1;
    assign w_rd_col   = 64'(r_col) + 64'(w_interior ? win_col(r_k) : 2'd1) - 64'd1;

    always_comb begin
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < WINDOW_SIZE; i++)
                w_chan[c][i] = r_win[i][c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
    end

    for (genvar g = 0; g < 3; g++) begin : g_med
        median9 u_median9 (
            .i_pix (w_chan[g]),
            .o_med (w_med[g*CHANNEL_WIDTH +: CHANNEL_WIDTH])
        );
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = Mf_Start ? FETCH : IDLE;
            FETCH:   w_next = w_last_k ? CAPTURE : FETCH;
            CAPTURE: w_next = w_interior ? COMPUTE : WRITE;
            COMPUTE: w_next = WRITE;
            WRITE:   w_next = w_last_pix ? DONE : FETCH;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Mf_Clk or negedge Mf_Reset_n) begin
        if (!Mf_Reset_n) begin
            r_state <= IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_cap_k <= '0;
            r_cap_v <= 1'b0;
            r_med   <= '0;
            for (int i = 0; i < WINDOW_SIZE; i++) r_win[i] <= '0;
        end else begin
            r_state <= w_next;
            r_cap_v <= r_state == FETCH;
            r_cap_k <= r_k;
            if (r_cap_v) r_win[r_cap_k] <= Mf_Mem_Read_Data;
            if (r_state == IDLE && Mf_Start) begin
                r_row <= '0;
                r_col <= '0;
            end
            if (r_state == FETCH) r_k <= w_last_k ? 4'd0 : r_k + 4'd1;
            if (r_state == COMPUTE) r_med <= w_med;
            if (r_state == WRITE && !w_last_pix) begin
                r_col <= w_last_col ? '0 : r_col + 1'b1;
                if (w_last_col) r_row <= r_row + 1'b1;
            end
        end
    end

    assign Mf_Busy              = r_state != IDLE && r_state != DONE;
    assign Mf_Done              = r_state == DONE;
    assign Mf_Mem_Read_Enable   = r_state == FETCH;
    assign Mf_Mem_Read_Address  = Mf_Mem_Read_Enable ? pix_addr(SRC_BASE, w_rd_row, w_rd_col) : '0;
    assign Mf_Mem_Write_Enable  = r_state == WRITE;
    assign Mf_Mem_Write_Address = Mf_Mem_Write_Enable ? pix_addr(DST_BASE, 64'(r_row), 64'(r_col)) : '0;
    assign Mf_Mem_Write_Data    = Mf_Mem_Write_Enable ? (w_interior ? r_med : r_win[0]) : '0;
endmodule

// File: tb/tb_median_filter_engine.sv
// tb_median_filter_engine: three engine instances (4x4, 3x3, 2x4) sharing one memory model,
// checked against an array-sorting reference of the 3x3 median filter.
module tb_median_filter_engine;
    localparam int unsigned DST = 2097152;

    typedef struct {
        logic [31:0] a;
        logic [23:0] v;
    } wr_t;

    typedef struct {
        logic [8:0][23:0] win;
        logic [23:0]      exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  start = '0;
    logic [2:0]  busy, done, rd_en, wr_en;
    logic [31:0] raddr [3];
    logic [31:0] waddr [3];
    logic [23:0] wdata [3];
    logic [23:0] rdata = '0;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;
    logic [23:0] img [$];
    wr_t         wlog [$];
    int          rcnt [3] = '{0, 0, 0};
    int          viol = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    median_filter_engine #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
        .Mf_Clk(clk), .Mf_Reset_n(rst_n), .Mf_Start(start[0]), .Mf_Busy(busy[0]), .Mf_Done(done[0]),
        .Mf_Mem_Read_Enable(rd_en[0]), .Mf_Mem_Read_Address(raddr[0]), .Mf_Mem_Read_Data(rdata),
        .Mf_Mem_Write_Enable(wr_en[0]), .Mf_Mem_Write_Address(waddr[0]), .Mf_Mem_Write_Data(wdata[0]));
    median_filter_engine #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) u_dut3 (
        .Mf_Clk(clk), .Mf_Reset_n(rst_n), .Mf_Start(start[1]), .Mf_Busy(busy[1]), .Mf_Done(done[1]),
        .Mf_Mem_Read_Enable(rd_en[1]), .Mf_Mem_Read_Address(raddr[1]), .Mf_Mem_Read_Data(rdata),
        .Mf_Mem_Write_Enable(wr_en[1]), .Mf_Mem_Write_Address(waddr[1]), .Mf_Mem_Write_Data(wdata[1]));
    median_filter_engine #(.IMG_WIDTH(2), .IMG_HEIGHT(4)) u_dut2 (
        .Mf_Clk(clk), .Mf_Reset_n(rst_n), .Mf_Start(start[2]), .Mf_Busy(busy[2]), .Mf_Done(done[2]),
        .Mf_Mem_Read_Enable(rd_en[2]), .Mf_Mem_Read_Address(raddr[2]), .Mf_Mem_Read_Data(rdata),
        .Mf_Mem_Write_Enable(wr_en[2]), .Mf_Mem_Write_Address(waddr[2]), .Mf_Mem_Write_Data(wdata[2]));

    // Strobes are observed mid-cycle; the memory answers on the following rising edge.
    always @(negedge clk) begin
        pend <= |rd_en;
        for (int d = 0; d < 3; d++) begin
            if (rd_en[d]) begin
                paddr <= raddr[d];
                rcnt[d]++;
                if (raddr[d] % 3 != 0 || raddr[d] / 3 >= img.size()) viol++;
            end
            if (wr_en[d]) wlog.push_back('{a: waddr[d], v: wdata[d]});
            if (rd_en[d] && wr_en[d]) viol++;
            if (!rd_en[d] && raddr[d] != '0) viol++;
            if (!wr_en[d] && (waddr[d] != '0 || wdata[d] != '0)) viol++;
        end
    end

    always @(posedge clk)
        if (pend) rdata <= (paddr % 3 == 0 && paddr / 3 < img.size()) ? img[paddr / 3] : 24'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit interior(input int r, input int c, input int w, input int h);
        return w >= 3 && h >= 3 && r >= 1 && r <= h - 2 && c >= 1 && c <= w - 2;
    endfunction

    function automatic logic [23:0] med9(input logic [8:0][23:0] win);
        logic [23:0] res;
        int q [$];
        res = '0;
        for (int ch = 0; ch < 3; ch++) begin
            q.delete();
            for (int i = 0; i < 9; i++) q.push_back(int'(win[i][ch*8 +: 8]));
            q.sort();
            res[ch*8 +: 8] = 8'(q[4]);
        end
        return res;
    endfunction

    function automatic logic [23:0] exp_pix(input int r, input int c, input int w, input int h);
        logic [8:0][23:0] win;
        if (!interior(r, c, w, h)) return img[r*w + c];
        for (int i = 0; i < 9; i++) win[i] = img[(r - 1 + i / 3) * w + c - 1 + i % 3];
        return med9(win);
    endfunction

    function automatic logic [31:0] outs_or(input int d);
        return {31'h0, |{busy[d], done[d], rd_en[d], wr_en[d], raddr[d], waddr[d], wdata[d]}};
    endfunction

    task automatic run(input int d, input bit pulse, output int cyc);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk("busy_after_start", 32'(busy[d]), 1);
        cyc = 0;
        while (done[d] !== 1'b1 && cyc < 5000) begin
            start[d] = pulse && (cyc == 10 || cyc == 40 || cyc == 41);
            @(negedge clk);
            cyc++;
        end
        start[d] = 1'b0;
        chk("done_seen", 32'(done[d]), 1);
        @(negedge clk);
        chk("idle_after_done", 32'({busy[d], done[d]}), 0);
    endtask

    task automatic check_image(input int d, input int w, input int h, input bit pulse, output int cyc);
        int wb, rb, ecyc, erd;
        wb = wlog.size();
        rb = rcnt[d];
        ecyc = 0;
        erd = 0;
        run(d, pulse, cyc);
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                ecyc += interior(r, c, w, h) ? 12 : 3;
                erd  += interior(r, c, w, h) ? 9 : 1;
            end
        chk("work_cycles", cyc, ecyc);
        chk("read_count", rcnt[d] - rb, erd);
        chk("write_count", wlog.size() - wb, w * h);
        for (int i = 0; i < w * h && wb + i < wlog.size(); i++) begin
            chk("dst_addr", wlog[wb + i].a, DST + 32'(i * 3));
            chk("dst_data", wlog[wb + i].v, exp_pix(i / w, i % w, w, h));
        end
    endtask

    initial begin
        vec_t tv [$];
        vec_t v;
        logic [7:0] rl [9] = '{0, 0, 0, 0, 255, 255, 255, 255, 7};
        logic [7:0] bl [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 200};
        int cyc, wb, rb, cum, nexp;

        // Reset held low with Start toggling: every output stays 0.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = (i % 2 == 0) ? 3'b111 : 3'b000;
            #1;
            for (int d = 0; d < 3; d++) chk("outs_in_reset", outs_or(d), 0);
        end
        start = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("no_reads_after_release", rcnt[0] + rcnt[1] + rcnt[2], 0);
        chk("no_writes_after_release", wlog.size(), 0);
        chk("idle_after_release", {29'h0, busy}, 0);

        // 4x4 flat image: every destination pixel equals the constant; 84 cycles of work.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(24'h102030);
        check_image(0, 4, 4, 1'b0, cyc);
        chk("flat4x4_cycles", cyc, 84);

        // 4x4 random images, one with Start pulses while busy, one with heavy channel ties.
        for (int t = 0; t < 3; t++) begin
            img.delete();
            for (int i = 0; i < 16; i++)
                img.push_back(t == 2 ? {8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(250, 255))}
                                     : 24'($urandom));
            check_image(0, 4, 4, t == 1, cyc);
        end

        // 3x3 window table: fixed vectors with hand-derived centres plus random ones.
        for (int i = 0; i < 9; i++) v.win[i] = 24'h0;
        v.win[4] = 24'hFFFFFF;
        v.exp = 24'h000000;
        tv.push_back(v);
        for (int i = 0; i < 9; i++) v.win[i] = {8'(i + 1), 8'(9 - i), 8'h80};
        v.exp = 24'h050580;
        tv.push_back(v);
        for (int i = 0; i < 9; i++) v.win[i] = 24'h102030;
        v.exp = 24'h102030;
        tv.push_back(v);
        for (int i = 0; i < 9; i++) v.win[i] = 24'hFFFFFF;
        v.win[4] = 24'h0;
        v.exp = 24'hFFFFFF;
        tv.push_back(v);
        for (int i = 0; i < 9; i++) v.win[i] = {rl[i], 8'h55, bl[i]};
        v.exp = 24'h075505;
        tv.push_back(v);
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 9; i++) v.win[i] = 24'($urandom);
            v.exp = med9(v.win);
            tv.push_back(v);
        end
        foreach (tv[t]) begin
            img.delete();
            for (int i = 0; i < 9; i++) img.push_back(tv[t].win[i]);
            wb = wlog.size();
            check_image(1, 3, 3, 1'b0, cyc);
            chk("table_centre", wlog.size() > wb + 4 ? {8'h0, wlog[wb + 4].v} : 32'hFFFFFFFF, {8'h0, tv[t].exp});
        end

        // 2x4 image: all border, straight copy, 24 cycles of work.
        img.delete();
        for (int i = 0; i < 8; i++) img.push_back(24'($urandom));
        wb = wlog.size();
        check_image(2, 2, 4, 1'b0, cyc);
        chk("narrow_cycles", cyc, 24);
        for (int i = 0; i < 8 && wb + i < wlog.size(); i++) chk("narrow_copy", wlog[wb + i].v, img[i]);

        // Reset 20 cycles into a 4x4 run: abort, keep earlier writes, no further strobes.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back(24'($urandom));
        wb = wlog.size();
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) chk("outs_on_async_reset", outs_or(d), 0);
        cum = 0;
        nexp = 0;
        for (int i = 0; i < 16; i++) begin
            cum += interior(i / 4, i % 4, 4, 4) ? 12 : 3;
            if (cum <= 20) nexp++;
        end
        chk("writes_before_reset", wlog.size() - wb, nexp);
        for (int i = 0; i < nexp && wb + i < wlog.size(); i++)
            chk("kept_write", wlog[wb + i].v, exp_pix(i / 4, i % 4, 4, 4));
        rb = rcnt[0];
        wb = wlog.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("no_read_after_abort", rcnt[0] - rb, 0);
        chk("no_write_after_abort", wlog.size() - wb, 0);
        chk("busy_done_after_abort", 32'({busy[0], done[0]}), 0);

        chk("protocol_violations", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
